// File: rtl/wb_commit_arbiter_if.sv
// Writeback-to-commit bus between the execution units and wb_commit_arbiter.
// Handshake: a unit holds unit_done with stable unit_id/unit_rd until it sees unit_ack
// high in the same cycle; an ack means that payload is taken at that rising edge.
interface wb_commit_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = 3,
  parameter int XLEN      = 32
);
  localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]        unit_done;
  logic [NUM_UNITS*ID_W-1:0]   unit_id;
  logic [NUM_UNITS*XLEN-1:0]   unit_rd;
  logic [NUM_UNITS-1:0]        unit_ack;
  logic                        commit_stall;

  logic [NUM_PORTS-1:0]        port_valid;
  logic [NUM_PORTS*ID_W-1:0]   port_id;
  logic [NUM_PORTS*XLEN-1:0]   port_data;
  logic [NUM_PORTS*UNIT_W-1:0] port_unit;

  logic                        store_waiting;
  logic [ID_W-1:0]             store_id_needed;
  logic                        store_ack;
  logic                        store_id_done;
  logic [XLEN-1:0]             store_data;

  modport master (
    output unit_done, unit_id, unit_rd, commit_stall,
    output store_waiting, store_id_needed, store_ack,
    input  unit_ack, port_valid, port_id, port_data, port_unit,
    input  store_id_done, store_data
  );

  modport slave (
    input  unit_done, unit_id, unit_rd, commit_stall,
    input  store_waiting, store_id_needed, store_ack,
    output unit_ack, port_valid, port_id, port_data, port_unit,
    output store_id_done, store_data
  );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Round-robin writeback arbiter granting up to NUM_PORTS commit ports per cycle.
// Store forwarding is built only when WB_COMMIT_ARB_STORE_FWD_EN is defined.
module wb_commit_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = 3,
  parameter int XLEN      = 32,
  localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  wb_commit_arbiter_if.slave  bus,
  output logic [UNIT_W-1:0]   dbg_rr_ptr
);

  logic [ID_W-1:0]   uid [NUM_UNITS];
  logic [XLEN-1:0]   urd [NUM_UNITS];

  logic [NUM_UNITS-1:0] ack_c;
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [UNIT_W-1:0]    gnt_unit [NUM_PORTS];
  logic [UNIT_W-1:0]    rr_ptr;
  logic [UNIT_W-1:0]    rr_next;
  logic                 grant_en;
  logic [UNIT_W:0]      scan_sum;
  logic [UNIT_W-1:0]    scan_idx;

  logic [NUM_PORTS-1:0] port_valid_q;
  logic [ID_W-1:0]      port_id_q   [NUM_PORTS];
  logic [XLEN-1:0]      port_data_q [NUM_PORTS];
  logic [UNIT_W-1:0]    port_unit_q [NUM_PORTS];

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
    assign uid[k] = bus.unit_id[k*ID_W +: ID_W];
    assign urd[k] = bus.unit_rd[k*XLEN +: XLEN];
  end

  // Reset and stall both suppress every grant, so acks are gated here only.
  assign grant_en = rst && !bus.commit_stall;

  // Ports fill in order; each scans circularly from rr_ptr skipping units already taken.
  always_comb begin
    ack_c     = '0;
    gnt_valid = '0;
    rr_next   = rr_ptr;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int p = 0; p < NUM_PORTS; p++) gnt_unit[p] = '0;
    if (grant_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          scan_sum = {1'b0, rr_ptr} + (UNIT_W+1)'(i);
          if (scan_sum >= (UNIT_W+1)'(NUM_UNITS))
            scan_sum = scan_sum - (UNIT_W+1)'(NUM_UNITS);
          scan_idx = scan_sum[UNIT_W-1:0];
          if (!gnt_valid[p] && bus.unit_done[scan_idx] && !ack_c[scan_idx]) begin
            gnt_valid[p]     = 1'b1;
            gnt_unit[p]      = scan_idx;
            ack_c[scan_idx]  = 1'b1;
            rr_next = (scan_idx == UNIT_W'(NUM_UNITS-1)) ? '0 : scan_idx + UNIT_W'(1);
          end
        end
      end
    end
  end

  assign bus.unit_ack = ack_c;
  assign dbg_rr_ptr   = rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr       <= '0;
      port_valid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_id_q[p]   <= '0;
        port_data_q[p] <= '0;
        port_unit_q[p] <= '0;
      end
    end else begin
      rr_ptr       <= rr_next;
      port_valid_q <= gnt_valid;
      // Unfilled ports keep their last payload; only the valid bit drops.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_valid[p]) begin
          port_id_q[p]   <= uid[gnt_unit[p]];
          port_data_q[p] <= urd[gnt_unit[p]];
          port_unit_q[p] <= gnt_unit[p];
        end
      end
    end
  end

  assign bus.port_valid = port_valid_q;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pack
    assign bus.port_id[p*ID_W +: ID_W]       = port_id_q[p];
    assign bus.port_data[p*XLEN +: XLEN]     = port_data_q[p];
    assign bus.port_unit[p*UNIT_W +: UNIT_W] = port_unit_q[p];
  end

`ifdef WB_COMMIT_ARB_STORE_FWD_EN
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic            store_id_done_q;
  logic [XLEN-1:0] store_data_q;

  // Descending scan so the lowest-numbered matching port wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int p = NUM_PORTS-1; p >= 0; p--) begin
      if (bus.store_waiting && gnt_valid[p] && (uid[gnt_unit[p]] == bus.store_id_needed)) begin
        fwd_hit  = 1'b1;
        fwd_data = urd[gnt_unit[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      store_id_done_q <= 1'b0;
      store_data_q    <= '0;
    end else if (bus.store_ack) begin
      store_id_done_q <= 1'b0;
    end else if (fwd_hit) begin
      store_id_done_q <= 1'b1;
      store_data_q    <= fwd_data;
    end
  end

  assign bus.store_id_done = store_id_done_q;
  assign bus.store_data    = store_data_q;
`else
  logic unused_store;
  assign unused_store      = ^{bus.store_waiting, bus.store_id_needed, bus.store_ack};
  assign bus.store_id_done = 1'b0;
  assign bus.store_data    = '0;
`endif

  // Grants only to requesting units, never while stalled, never more than the port count.
  a_ack_req:   assert property (@(posedge clk) (ack_c & ~bus.unit_done) == '0);
  a_ack_stall: assert property (@(posedge clk) bus.commit_stall |-> (ack_c == '0));
  a_ack_cnt:   assert property (@(posedge clk) $countones(ack_c) <= NUM_PORTS);
  a_rr_range:  assert property (@(posedge clk) int'(rr_ptr) < NUM_UNITS);

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: rotation-list reference model checked every
// cycle, plus literal expectations for the key arbitration, stall, forwarding and reset cases.
module tb_wb_commit_arbiter;
  localparam int NU  = 4;
  localparam int NP  = 2;
  localparam int IDW = 3;
  localparam int XL  = 32;
  localparam int UW  = 2;
`ifdef WB_COMMIT_ARB_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [UW-1:0] dbg_rr_ptr;
  bit            chk_en = 1'b0;
  int            n_tests = 0;
  int            n_fail  = 0;

  wb_commit_arbiter_if #(.NUM_UNITS(NU), .NUM_PORTS(NP), .ID_W(IDW), .XLEN(XL)) bus ();

  wb_commit_arbiter #(.NUM_UNITS(NU), .NUM_PORTS(NP), .ID_W(IDW), .XLEN(XL)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IDW-1:0] get_uid(input int u);
    return bus.unit_id[u*IDW +: IDW];
  endfunction

  function automatic logic [XL-1:0] get_urd(input int u);
    return bus.unit_rd[u*XL +: XL];
  endfunction

  // Walk the units in rotation order from rr and keep the first NP requesters.
  function automatic logic [NU-1:0] model_ack(input logic [NU-1:0] done, input int rr);
    logic [NU-1:0] a;
    int got;
    a = '0;
    got = 0;
    for (int i = 0; i < NU; i++) begin
      int u;
      u = (rr + i) % NU;
      if (done[u] && got < NP) begin
        a[u] = 1'b1;
        got++;
      end
    end
    return a;
  endfunction

  // Port n carries the n-th granted unit met in rotation order.
  function automatic int nth_granted(input logic [NU-1:0] a, input int rr, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < NU; i++) begin
      int u;
      u = (rr + i) % NU;
      if (a[u]) begin
        if (seen == n) return u;
        seen++;
      end
    end
    return 0;
  endfunction

  // ---------------- reference model ----------------
  int                m_rr;
  logic [NP-1:0]     m_valid;
  logic [IDW-1:0]    m_id   [NP];
  logic [XL-1:0]     m_data [NP];
  int                m_unit [NP];
  logic              m_sdone;
  logic [XL-1:0]     m_sdata;
  logic [IDW+XL-1:0] exp_q [$];

  initial begin
    m_rr = 0; m_valid = '0; m_sdone = 1'b0; m_sdata = '0;
    for (int p = 0; p < NP; p++) begin m_id[p] = '0; m_data[p] = '0; m_unit[p] = 0; end
  end

  always @(posedge clk) begin : model
    logic [NU-1:0] a;
    int            cnt;
    int            u;
    bit            hit;
    logic [XL-1:0] hdata;
    if (!rst) begin
      m_rr = 0; m_valid = '0; m_sdone = 1'b0; m_sdata = '0;
      for (int p = 0; p < NP; p++) begin m_id[p] = '0; m_data[p] = '0; m_unit[p] = 0; end
      exp_q.delete();
    end else begin
      a = bus.commit_stall ? '0 : model_ack(bus.unit_done, m_rr);
      cnt = $countones(a);
      m_valid = '0;
      hit = 1'b0;
      hdata = '0;
      for (int p = 0; p < cnt; p++) begin
        u = nth_granted(a, m_rr, p);
        m_valid[p] = 1'b1;
        m_id[p]    = get_uid(u);
        m_data[p]  = get_urd(u);
        m_unit[p]  = u;
        exp_q.push_back({m_id[p], m_data[p]});
        if (!hit && bus.store_waiting && m_id[p] == bus.store_id_needed) begin
          hit = 1'b1;
          hdata = m_data[p];
        end
      end
`ifdef WB_COMMIT_ARB_STORE_FWD_EN
      if (bus.store_ack) m_sdone = 1'b0;
      else if (hit) begin m_sdone = 1'b1; m_sdata = hdata; end
`endif
      if (cnt > 0) m_rr = (nth_granted(a, m_rr, cnt - 1) + 1) % NU;
    end
  end

  // ---------------- per-cycle compare (scoreboard) ----------------
  always @(negedge clk) begin : compare
    logic [NU-1:0]     ea;
    logic [IDW+XL-1:0] pl;
    if (chk_en) begin
      ea = (!rst || bus.commit_stall) ? '0 : model_ack(bus.unit_done, m_rr);
      check("unit_ack", 64'(bus.unit_ack), 64'(ea));
      check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_rr));
      check("port_valid", 64'(bus.port_valid), 64'(m_valid));
      for (int p = 0; p < NP; p++) begin
        if (m_valid[p]) begin
          pl = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          check("port_payload", 64'({bus.port_id[p*IDW +: IDW], bus.port_data[p*XL +: XL]}), 64'(pl));
        end
        check("port_id", 64'(bus.port_id[p*IDW +: IDW]), 64'(m_id[p]));
        check("port_data", 64'(bus.port_data[p*XL +: XL]), 64'(m_data[p]));
        check("port_unit", 64'(bus.port_unit[p*UW +: UW]), 64'(m_unit[p]));
      end
      check("store_id_done", 64'(bus.store_id_done), 64'(m_sdone));
      check("store_data", 64'(bus.store_data), 64'(m_sdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic [NU-1:0] done, input logic stall, input logic sack);
    @(posedge clk);
    #1;
    rst              = r;
    bus.unit_done    = done;
    bus.commit_stall = stall;
    bus.store_ack    = sack;
    @(negedge clk);
  endtask

  task automatic set_unit(input int k, input logic [IDW-1:0] id, input logic [XL-1:0] rd);
    bus.unit_id[k*IDW +: IDW] = id;
    bus.unit_rd[k*XL +: XL]   = rd;
  endtask

  // {store_ack, stall, done}
  logic [NU+1:0] vec [16] = '{
    6'b0_0_1111, 6'b0_0_1010, 6'b0_0_0101, 6'b0_1_1111,
    6'b0_0_1000, 6'b1_0_0111, 6'b0_0_0000, 6'b0_0_0011,
    6'b0_0_1100, 6'b0_1_0001, 6'b0_0_0110, 6'b1_0_1111,
    6'b0_0_1001, 6'b0_0_0001, 6'b0_0_1110, 6'b0_0_1111
  };

  // ---------------- stimulus ----------------
  initial begin
    bus.unit_done       = '0;
    bus.commit_stall    = 1'b0;
    bus.store_waiting   = 1'b0;
    bus.store_id_needed = '0;
    bus.store_ack       = 1'b0;
    bus.unit_id         = '0;
    bus.unit_rd         = '0;
    for (int k = 0; k < NU; k++) set_unit(k, IDW'(k), 32'hA000_0000 + XL'(k));

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_port_valid", 64'(bus.port_valid), 64'd0);
    check("reset_rr", 64'(dbg_rr_ptr), 64'd0);
    check("reset_ack", 64'(bus.unit_ack), 64'd0);
    check("reset_port_data", 64'(bus.port_data), 64'd0);

    // All four requesting: pairs {0,1},{2,3},{0,1}, rr 0,2,0.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("rr_burst_ack0", 64'(bus.unit_ack), 64'b0011);
    check("rr_burst_ptr0", 64'(dbg_rr_ptr), 64'd0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("rr_burst_ack1", 64'(bus.unit_ack), 64'b1100);
    check("rr_burst_ptr1", 64'(dbg_rr_ptr), 64'd2);
    check("rr_burst_valid1", 64'(bus.port_valid), 64'b11);
    check("rr_burst_units1", 64'(bus.port_unit), 64'b0100);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("rr_burst_ack2", 64'(bus.unit_ack), 64'b0011);
    check("rr_burst_ptr2", 64'(dbg_rr_ptr), 64'd0);
    check("rr_burst_units2", 64'(bus.port_unit), 64'b1110);

    // Single requester lands on port 0.
    set_unit(2, 3'd5, 32'hDEAD_BEEF);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    check("single_ack", 64'(bus.unit_ack), 64'b0100);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("single_valid", 64'(bus.port_valid), 64'b01);
    check("single_id", 64'(bus.port_id[IDW-1:0]), 64'd5);
    check("single_data", 64'(bus.port_data[XL-1:0]), 64'hDEAD_BEEF);
    check("single_unit", 64'(bus.port_unit[UW-1:0]), 64'd2);
    check("single_rr", 64'(dbg_rr_ptr), 64'd3);

    // Wrap: rr=3 with units 3 and 0 requesting.
    step(1'b1, 4'b1001, 1'b0, 1'b0);
    check("wrap_rr_before", 64'(dbg_rr_ptr), 64'd3);
    check("wrap_ack", 64'(bus.unit_ack), 64'b1001);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("wrap_units", 64'(bus.port_unit), 64'b0011);
    check("wrap_rr_after", 64'(dbg_rr_ptr), 64'd1);

    // Three stalled cycles, then release.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0001, 1'b1, 1'b0);
      check("stall_ack", 64'(bus.unit_ack), 64'd0);
      check("stall_valid", 64'(bus.port_valid), 64'd0);
    end
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check("unstall_ack", 64'(bus.unit_ack), 64'b0001);
    check("unstall_valid_t", 64'(bus.port_valid), 64'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("unstall_valid_t1", 64'(bus.port_valid), 64'b01);

    // Store forwarding: capture, then ack beating a fresh match.
    set_unit(1, 3'd6, 32'h1234_5678);
    bus.store_waiting   = 1'b1;
    bus.store_id_needed = 3'd6;
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    check("fwd_ack", 64'(bus.unit_ack), 64'b0010);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("fwd_done", 64'(bus.store_id_done), FWD ? 64'd1 : 64'd0);
    check("fwd_data", 64'(bus.store_data), FWD ? 64'h1234_5678 : 64'd0);
    step(1'b1, 4'b0010, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("fwd_ack_priority", 64'(bus.store_id_done), 64'd0);
    check("fwd_data_hold", 64'(bus.store_data), FWD ? 64'h1234_5678 : 64'd0);

    // Two matching grants in one cycle: port 0 (unit 0) wins.
    set_unit(0, 3'd6, 32'h0000_AAAA);
    set_unit(1, 3'd6, 32'h0000_BBBB);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("fwd_low_port_done", 64'(bus.store_id_done), FWD ? 64'd1 : 64'd0);
    check("fwd_low_port_data", 64'(bus.store_data), FWD ? 64'h0000_AAAA : 64'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);

    // Mixed vectors, checked against the model every cycle.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NU; k++) set_unit(k, IDW'(i + k), 32'hC0DE_0000 + XL'(i * 16 + k));
      bus.store_id_needed = IDW'(i * 3);
      step(1'b1, vec[i][NU-1:0], vec[i][NU], vec[i][NU+1]);
    end
    bus.store_waiting = 1'b0;

    // Reset in the middle of a full burst.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    check("midreset_ack", 64'(bus.unit_ack), 64'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("midreset_rr", 64'(dbg_rr_ptr), 64'd0);
    check("midreset_valid", 64'(bus.port_valid), 64'd0);
    check("midreset_id", 64'(bus.port_id), 64'd0);
    check("midreset_data", 64'(bus.port_data), 64'd0);
    check("midreset_unit", 64'(bus.port_unit), 64'd0);
    check("midreset_sdone", 64'(bus.store_id_done), 64'd0);
    check("midreset_sdata", 64'(bus.store_data), 64'd0);
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_commit_arbiter.md
WB_COMMIT_ARBITER -- requirements
Module: wb_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4: number of writeback requesters.
REQ-002 SHALL have parameter NUM_PORTS, default 2: number of commit ports granted per cycle, legal range 1..NUM_UNITS.
REQ-003 SHALL have parameter ID_W, default 3: instruction-ID width.
REQ-004 SHALL have parameter XLEN, default 32: data width.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port unit_done, input, NUM_UNITS: per-unit result-ready request.
REQ-009 SHALL have port unit_id, input, NUM_UNITS*ID_W: per-unit instruction ID, unit k in bits [k*ID_W +: ID_W].
REQ-010 SHALL have port unit_rd, input, NUM_UNITS*XLEN: per-unit result data, flattened in the same way as unit_id.
REQ-011 SHALL have port unit_ack, output, NUM_UNITS: per-unit grant, combinational, same cycle as the grant.
REQ-012 SHALL have port commit_stall, input, 1: register-file write ports unavailable this cycle.
REQ-013 SHALL have ports port_valid (NUM_PORTS), port_id (NUM_PORTS*ID_W), port_data (NUM_PORTS*XLEN) and port_unit (NUM_PORTS*$clog2(NUM_UNITS)), all outputs and all registered: the commit-port payload.
REQ-014 SHALL have ports store_waiting (in, 1), store_id_needed (in, ID_W), store_ack (in, 1), store_id_done (out, 1) and store_data (out, XLEN): the store-forwarding interface.

Function
REQ-015 SHALL, each cycle with commit_stall=0, assign ports in order 0..NUM_PORTS-1; each port takes the first unit k with unit_done[k]=1 that is not yet acked this cycle, searching circularly from rr_ptr.
REQ-016 SHALL assert unit_ack[k] for exactly the units granted in REQ-015, and assert at most one ack per unit per cycle.
REQ-017 SHALL assert no unit_ack while commit_stall=1, and SHALL clear all port_valid bits in the next cycle.
REQ-018 SHALL register the grant: a unit acked in cycle t appears in cycle t+1 with port_valid=1 and its ID, data and unit index on the port that granted it.
REQ-019 SHALL clear the port_valid bit of every port left unfilled in cycle t in cycle t+1, and SHALL hold that port's id, data and unit fields at their previous values.
REQ-020 SHALL update rr_ptr to (highest-numbered port's granted unit + 1) mod NUM_UNITS after any cycle with at least one grant, and SHALL hold it otherwise; wrap from NUM_UNITS-1 to 0.
REQ-021 SHALL grant every continuously requesting unit within ceil(NUM_UNITS/NUM_PORTS) non-stalled cycles.
REQ-022 (store fwd) SHALL, when store_waiting=1 and a granted unit's unit_id equals store_id_needed in cycle t, capture that unit's unit_rd into store_data and set store_id_done=1 at t+1.
REQ-023 SHALL, when several granted units match in the same cycle, capture from the lowest-numbered port.
REQ-024 SHALL clear store_id_done on store_ack, SHALL give store_ack priority over a simultaneous match, and SHALL hold store_data until the next capture.

Reset
REQ-025 SHALL, when rst=0 at a clock edge, reset rr_ptr=0, port_valid=0, port_id=0, port_data=0, port_unit=0, store_id_done=0 and store_data=0.
REQ-026 SHALL force unit_ack=0 combinationally while rst=0.
REQ-027 SHALL treat reset mid-operation as discarding any acked-but-unregistered grant.

Configuration
REQ-028 SHALL compile REQ-022..REQ-024 in only when macro WB_COMMIT_ARB_STORE_FWD_EN is defined.
REQ-029 SHALL, without WB_COMMIT_ARB_STORE_FWD_EN, drive store_id_done and store_data to constant 0, ignore the store inputs, and remove the capture registers.

Verification
REQ-030 SHALL check NUM_UNITS=4, NUM_PORTS=2, rr_ptr=0, unit_done=4'b1111 held: units {0,1} are acked, then {2,3}, then {0,1}; rr_ptr sequence is 0,2,0.
REQ-031 SHALL check unit_done=4'b0100 with unit_id[2]=5 and unit_rd[2]=0xDEADBEEF: unit_ack=4'b0100 at t; at t+1 port_valid=2'b01, port_id[0]=5, port_data[0]=0xDEADBEEF, port_unit[0]=2.
REQ-032 SHALL check commit_stall=1 for 3 cycles with unit_done=4'b0001: unit_ack=0 and port_valid=0 throughout; stall drops at t, unit_ack[0]=1 at t, port_valid[0]=1 at t+1.
REQ-033 SHALL check rr_ptr=3 with unit_done=4'b1001: port0 grants unit 3, port1 grants unit 0, and rr_ptr becomes 1.
REQ-034 SHALL check store_waiting=1, store_id_needed=6, and unit 1 granted with id 6 and data 0x12345678: store_id_done=1 and store_data=0x12345678 at t+1; store_ack together with a new match keeps store_id_done=0.
REQ-035 SHALL check rst=0 asserted mid-burst with unit_done=4'b1111: unit_ack=0 that cycle, and all outputs and rr_ptr are 0 after the edge.
